// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and execute-side resolution signals of the branch predictor.
// ex_valid is a one-cycle qualifier with no backpressure: each cycle it is high,
// one branch resolves and is consumed on that rising edge.
interface branch_predict_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [31:0]       if_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [2:0]        ex_mode;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [31:0]       ex_target;
  logic              ex_pred_taken;
  logic [31:0]       ex_pred_target;
  logic              ex_taken;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_mode, ex_a, ex_b, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, ex_taken, mispredict, redirect_pc,
           branch_cnt, miss_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_mode, ex_a, ex_b, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, ex_taken, mispredict, redirect_pc,
           branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB with 2-bit counters, branch outcome evaluation,
// registered flush/redirect and saturating performance counters.
module branch_predict_unit #(
  parameter int DATA_W   = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic              mispredict_q, mispredict_d;
  logic [31:0]       redirect_q, redirect_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit, taken, miss, a_zero, a_sign;
  logic [1:0]          ctr_upd;
  logic                unused_pc_bits;

  assign if_idx = bp.if_pc[IDX_BITS+1:2];
  assign if_tag = bp.if_pc[31:IDX_BITS+2];
  assign ex_idx = bp.ex_pc[IDX_BITS+1:2];
  assign ex_tag = bp.ex_pc[31:IDX_BITS+2];
  assign unused_pc_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bp.pred_taken  = if_hit && ctr_q[if_idx][1];
  assign bp.pred_target = if_hit ? tgt_q[if_idx] : bp.if_pc + 32'd4;

  assign a_zero = (bp.ex_a == '0);
  assign a_sign = bp.ex_a[DATA_W-1];

  always_comb begin
    taken = 1'b0;
    case (bp.ex_mode)
      3'd0: taken = (bp.ex_a == bp.ex_b);
      3'd1: taken = (bp.ex_a != bp.ex_b);
      3'd2: taken = a_sign;
      3'd3: taken = !a_sign;
      3'd4: taken = a_sign || a_zero;
      3'd5: taken = !a_sign && !a_zero;
      3'd6: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign bp.ex_taken = taken;
  assign miss = bp.ex_valid &&
                ((taken != bp.ex_pred_taken) ||
                 (taken && (bp.ex_pred_target != bp.ex_target)));

  always_comb begin
    ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ctr_upd = taken ? 2'b10 : 2'b01;
    if (ex_hit) begin
      if (taken) ctr_upd = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
      else       ctr_upd = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
    end
    mispredict_d = miss;
    redirect_d   = redirect_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (bp.ex_valid) begin
      redirect_d = taken ? bp.ex_target : bp.ex_pc + 32'd4;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      if (bp.ex_valid) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= ctr_upd;
      end
    end
  end

  // Tag/target storage needs no reset: entries are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (rst_n && bp.ex_valid) begin
      if (!ex_hit) tag_q[ex_idx] <= ex_tag;
      if (taken)   tgt_q[ex_idx] <= bp.ex_target;
    end
  end

  assign bp.mispredict  = mispredict_q;
  assign bp.redirect_pc = redirect_q;
  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.miss_cnt    = miss_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized and directed bench for branch_predict_unit against a table model;
// a second instance with 4-bit counters shares the stimulus to reach saturation.
module tb_branch_predict_unit;
  localparam int DATA_W   = 32;
  localparam int IDX_BITS = 6;
  localparam int CNT_W    = 16;
  localparam int ENTRIES  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bp ();
  branch_predict_unit_if #(.DATA_W(DATA_W), .CNT_W(4))     bp4 ();

  branch_predict_unit #(.DATA_W(DATA_W), .IDX_BITS(IDX_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bp(bp.slave));
  branch_predict_unit #(.DATA_W(DATA_W), .IDX_BITS(IDX_BITS), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bp(bp4.slave));

  assign bp4.if_pc          = bp.if_pc;
  assign bp4.ex_valid       = bp.ex_valid;
  assign bp4.ex_pc          = bp.ex_pc;
  assign bp4.ex_mode        = bp.ex_mode;
  assign bp4.ex_a           = bp.ex_a;
  assign bp4.ex_b           = bp.ex_b;
  assign bp4.ex_target      = bp.ex_target;
  assign bp4.ex_pred_taken  = bp.ex_pred_taken;
  assign bp4.ex_pred_target = bp.ex_pred_target;

  // Reference model: one record per table slot, counters as plain integers.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_mis;
  logic [31:0] m_redir;
  int          m_branch, m_miss;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit outcome(input int mode, input logic [31:0] a, input logic [31:0] b);
    case (mode)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) < 0;
      3: return $signed(a) >= 0;
      4: return $signed(a) <= 0;
      5: return $signed(a) > 0;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int s;
    bit hit;
    s   = slot_of(pc);
    hit = m_valid[s] && (m_tag[s] == tag_of(pc));
    t   = hit && (m_ctr[s] >= 2);
    tgt = hit ? m_tgt[s] : pc + 32'd4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_mis = 1'b0; m_redir = '0; m_branch = 0; m_miss = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input int mode,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptg);
    bp.ex_valid = v; bp.ex_pc = pc; bp.ex_mode = 3'(mode);
    bp.ex_a = a; bp.ex_b = b; bp.ex_target = tgt;
    bp.ex_pred_taken = pt; bp.ex_pred_target = ptg;
  endtask

  // Entered 1 time unit after a rising edge with inputs applied; leaves likewise.
  task automatic step();
    bit pt, act, miss;
    logic [31:0] ptg;
    int s;
    int cap16, cap4;
    #3;
    predict(bp.if_pc, pt, ptg);
    check_eq("pred_taken", 64'(bp.pred_taken), 64'(pt));
    check_eq("pred_target", 64'(bp.pred_target), 64'(ptg));
    check_eq("pred_target_w4", 64'(bp4.pred_target), 64'(ptg));
    act = outcome(int'(bp.ex_mode), bp.ex_a, bp.ex_b);
    check_eq("ex_taken", 64'(bp.ex_taken), 64'(act));
    miss = bp.ex_valid && ((act != bp.ex_pred_taken) ||
                           (act && (bp.ex_pred_target != bp.ex_target)));
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_mis = miss;
      if (bp.ex_valid) begin
        s = slot_of(bp.ex_pc);
        m_redir = act ? bp.ex_target : bp.ex_pc + 32'd4;
        if (m_valid[s] && m_tag[s] == tag_of(bp.ex_pc))
          m_ctr[s] = act ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
        else begin
          m_valid[s] = 1'b1;
          m_tag[s]   = tag_of(bp.ex_pc);
          m_ctr[s]   = act ? 2 : 1;
        end
        if (act) m_tgt[s] = bp.ex_target;
        m_branch++;
        if (miss) m_miss++;
      end
    end
    #1;
    check_eq("mispredict", 64'(bp.mispredict), 64'(m_mis));
    check_eq("redirect_pc", 64'(bp.redirect_pc), 64'(m_redir));
    cap16 = (1 << CNT_W) - 1;
    cap4  = 15;
    check_eq("branch_cnt", 64'(bp.branch_cnt), 64'((m_branch < cap16) ? m_branch : cap16));
    check_eq("miss_cnt", 64'(bp.miss_cnt), 64'((m_miss < cap16) ? m_miss : cap16));
    check_eq("branch_cnt_w4", 64'(bp4.branch_cnt), 64'((m_branch < cap4) ? m_branch : cap4));
    check_eq("miss_cnt_w4", 64'(bp4.miss_cnt), 64'((m_miss < cap4) ? m_miss : cap4));
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2);
  endfunction

  logic [3:0] sweep_exp [3];
  logic [31:0] sweep_a [3];

  initial begin
    bit pt;
    logic [31:0] ptg, pc, a, b;
    logic [3:0] exp_bits;
    int mode;

    bp.if_pc = 32'h0040_0010;
    drive(1'b0, '0, 7, '0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Cold lookup after reset.
    step();
    check_eq("cold_pred_taken", 64'(bp.pred_taken), 64'd0);
    check_eq("cold_pred_target", 64'(bp.pred_target), 64'h0040_0014);

    // First taken resolution allocates and flushes.
    drive(1'b1, 32'h0040_0010, 0, 32'd5, 32'd5, 32'h0040_0100, 1'b0, 32'h0040_0014);
    step();
    check_eq("first_mis", 64'(bp.mispredict), 64'd1);
    check_eq("first_redirect", 64'(bp.redirect_pc), 64'h0040_0100);
    check_eq("first_miss_cnt", 64'(bp.miss_cnt), 64'd1);
    bp.ex_valid = 1'b0;
    #2;
    check_eq("learned_taken", 64'(bp.pred_taken), 64'd1);
    check_eq("learned_target", 64'(bp.pred_target), 64'h0040_0100);
    step();

    repeat (4) begin
      drive(1'b1, 32'h0040_0010, 6, '0, '0, 32'h0040_0100, 1'b1, 32'h0040_0100);
      step();
    end
    drive(1'b1, 32'h0040_0010, 1, 32'd5, 32'd5, 32'h0040_0100, 1'b1, 32'h0040_0100);
    step();
    check_eq("nt_redirect", 64'(bp.redirect_pc), 64'h0040_0014);
    check_eq("nt_mis", 64'(bp.mispredict), 64'd1);
    bp.ex_valid = 1'b0;
    #2;
    check_eq("ctr2_still_taken", 64'(bp.pred_taken), 64'd1);

    // Zero-compare mode sweep (combinational only; idle edges just clear mispredict).
    sweep_a[0] = 32'hFFFF_FFFF; sweep_exp[0] = 4'b1010;
    sweep_a[1] = 32'h0000_0000; sweep_exp[1] = 4'b0110;
    sweep_a[2] = 32'h0000_0001; sweep_exp[2] = 4'b0101;
    for (int v = 0; v < 3; v++) begin
      exp_bits = sweep_exp[v];
      for (int m = 0; m < 4; m++) begin
        bp.ex_mode = 3'(m + 2);
        bp.ex_a = sweep_a[v];
        #1;
        check_eq($sformatf("sweep_v%0d_m%0d", v, m + 2), 64'(bp.ex_taken), 64'(exp_bits[3-m]));
      end
    end
    @(posedge clk);
    #1;
    m_mis = 1'b0;

    // Aliasing entry evicts the original branch.
    drive(1'b1, 32'h0040_0110, 0, 32'd7, 32'd7, 32'h0040_0200, 1'b0, 32'h0040_0114);
    step();
    bp.ex_valid = 1'b0;
    bp.if_pc = 32'h0040_0010;
    #2;
    check_eq("alias_pred_taken", 64'(bp.pred_taken), 64'd0);
    check_eq("alias_pred_target", 64'(bp.pred_target), 64'h0040_0014);
    step();

    // Reset wins over a resolving, mispredicting branch.
    drive(1'b1, 32'h0040_0020, 6, '0, '0, 32'h0040_0300, 1'b0, 32'h0040_0024);
    rst_n = 1'b0;
    step();
    check_eq("rst_no_mis", 64'(bp.mispredict), 64'd0);
    check_eq("rst_branch_cnt", 64'(bp.branch_cnt), 64'd0);
    rst_n = 1'b1;

    // PC+4 wraps at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 7, '0, '0, 32'h0000_1000, 1'b0, 32'h0000_0000);
    step();
    check_eq("wrap_redirect", 64'(bp.redirect_pc), 64'h0000_0000);

    // Twenty mispredicts saturate the 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h0040_0040 + 32'(i * 4), 6, '0, '0, 32'h0050_0000, 1'b0, 32'h0040_0044);
      step();
    end
    check_eq("sat_branch_cnt_w4", 64'(bp4.branch_cnt), 64'd15);
    check_eq("sat_miss_cnt_w4", 64'(bp4.miss_cnt), 64'd15);

    // Randomized traffic over a small PC pool so slots collide often.
    for (int n = 0; n < 500; n++) begin
      pc = rand_pc();
      mode = int'($urandom_range(0, 7));
      b = ($urandom_range(0, 1) == 0) ? 32'd5 : $urandom;
      case ($urandom_range(0, 4))
        0: a = 32'd0;
        1: a = 32'd1;
        2: a = 32'hFFFF_FFFF;
        3: a = b;
        default: a = $urandom;
      endcase
      predict(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) pt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ptg = rand_pc();
      drive($urandom_range(0, 4) != 0, pc, mode, a, b, rand_pc() + 32'h0010_0000 * 32'($urandom_range(0, 1)), pt, ptg);
      bp.if_pc = ($urandom_range(0, 1) == 0) ? pc : rand_pc();
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
